fifo_stream_reader: RTL and testbench

Read-side companion for the team's synchronous FIFO. It drains the FIFO by issuing `fifo_rd_en` and captures the registered `fifo_dout` one cycle later. It re-presents the words as a valid/ready stream with a `m_last` marker every `BURST_LEN` words. A 2-entry output buffer hides the FIFO's 1-cycle read latency, so throughput is a sustained 1 word/cycle.

---
 rtl/fifo_stream_reader.sv | 89 ++++++++
 tb/tb_fifo_stream_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO and re-presents its words as a
// valid/ready stream with a last marker every BURST_LEN words.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

    logic       pop;
    logic       capture;
    logic [2:0] level;
    logic [1:0] base;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf0_q;
    assign m_last  = m_valid & (beat_q == LAST_BEAT);

    always_comb begin
        pop     = m_valid & m_ready;
        // Counting this cycle's pop lets reads resume as soon as space frees.
        level   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = !rst & !flush & !fifo_empty & (level < 3'd2);
        capture = inflight_q & !flush;
        base    = occ_q - {1'b0, pop};

        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (capture) begin
            if (base == 2'd0) begin
                buf0_d = fifo_dout;
            end else begin
                buf1_d = fifo_dout;
            end
        end

        occ_d      = base + {1'b0, capture};
        inflight_d = fifo_rd_en;

        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
        end

        if (flush) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            beat_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO and stream scoreboard,
// three instances (BURST_LEN 4, 1, 3) sharing one stimulus.
module tb_fifo_stream_reader;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       m_ready;
    logic [2:0] rd;
    logic [2:0] vld;
    logic [2:0] lst;
    logic [7:0] dat [3];

    int blen [3] = '{4, 1, 3};

    fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4)) u_l4 (
        .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(rd[0]), .m_valid(vld[0]),
        .m_ready(m_ready), .m_data(dat[0]), .m_last(lst[0])
    );
    fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(1)) u_l1 (
        .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(rd[1]), .m_valid(vld[1]),
        .m_ready(m_ready), .m_data(dat[1]), .m_last(lst[1])
    );
    fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(3)) u_l3 (
        .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(rd[2]), .m_valid(vld[2]),
        .m_ready(m_ready), .m_data(dat[2]), .m_last(lst[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] fifo_q [$];
    logic [7:0] sb_q [$];
    logic [7:0] pop_d_q [$];
    logic       pop_l_q [$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_deliv = 0;
    int cnt = 0;
    int rd_cnt = 0;
    int rst_cyc = 0;

    logic       s_rd;
    logic       s_vld;
    logic       s_lst;
    logic [7:0] s_dat;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample just before the edge, check, advance the model.
    task automatic cycle();
        logic [7:0] w;
        logic       took;
        w = 8'h00;
        #4;
        s_rd  = rd[0];
        s_vld = vld[0];
        s_dat = dat[0];
        s_lst = lst[0];
        for (int i = 0; i < 3; i++) begin
            if (rd[i]) chk("rd_when_empty", 32'(fifo_empty), 0);
            if (rst || flush) chk("rd_in_rst_flush", 32'(rd[i]), 0);
            if (vld[i]) begin
                chk("data_present", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) chk("m_data", 32'(dat[i]), 32'(sb_q[0]));
                chk("m_last", 32'(lst[i]),
                    32'((cnt % blen[i]) == blen[i] - 1));
            end else begin
                chk("m_last_idle", 32'(lst[i]), 0);
            end
            if (rst && rst_cyc > 0) begin
                chk("rst_valid", 32'(vld[i]), 0);
                chk("rst_data", 32'(dat[i]), 0);
            end
        end
        took = s_rd;
        if (s_vld && m_ready) begin
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            pop_d_q.push_back(s_dat);
            pop_l_q.push_back(s_lst);
            n_deliv++;
            cnt++;
        end
        if (rst || flush) begin
            sb_q.delete();
            cnt = 0;
        end
        if (took && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            sb_q.push_back(w);
            rd_cnt++;
        end
        if (rst) rst_cyc++;
        else rst_cyc = 0;
        @(posedge clk);
        #1;
        if (took) fifo_dout = w;
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        m_ready = 1'b1;
        while ((vld[0] || sb_q.size() > 0 || fifo_q.size() > 0) && k < 60) begin
            cycle();
            k++;
        end
        chk(tag, 32'(k < 60), 1);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b1;
        fifo_dout = 8'h00;
        fifo_empty = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(8'(i));

        repeat (3) begin
            cycle();
            chk("rst_rd", 32'(s_rd), 0);
            chk("rst_m_valid", 32'(s_vld), 0);
            chk("rst_m_last", 32'(s_lst), 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i < 2) begin
                chk("fill_rd", 32'(s_rd), 1);
                chk("fill_valid", 32'(s_vld), 0);
            end else begin
                chk("stream_valid", 32'(s_vld), 1);
                chk("stream_data", 32'(s_dat), i - 1);
                chk("stream_last", 32'(s_lst), 32'(((i - 1) % 4) == 0));
            end
        end
        drain("stream_drain");
        chk("stream_count", n_deliv, 8);

        m_ready = 1'b0;
        rd_cnt = 0;
        d0 = n_deliv;
        for (int i = 0; i < 8; i++) push_word(8'(8'h11 + i));
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i >= 2) begin
                chk("bp_valid", 32'(s_vld), 1);
                chk("bp_hold", 32'(s_dat), 32'h11);
            end
        end
        chk("bp_reads", rd_cnt, 2);
        m_ready = 1'b1;
        cycle();
        chk("bp_resume_rd", 32'(s_rd), 1);
        chk("bp_first_pop", 32'(s_dat), 32'h11);
        drain("bp_drain");
        chk("bp_count", n_deliv - d0, 8);

        rd_cnt = 0;
        d0 = n_deliv;
        pop_d_q.delete();
        pop_l_q.delete();
        push_word(8'hA5);
        repeat (6) cycle();
        chk("eb_reads", rd_cnt, 1);
        chk("eb_words", n_deliv - d0, 1);
        chk("eb_data", 32'(pop_d_q[0]), 32'hA5);
        chk("eb_last", 32'(pop_l_q[0]), 0);
        push_word(8'h5A);
        push_word(8'h5B);
        push_word(8'h5C);
        drain("eb_drain");
        chk("eb_next_data", 32'(pop_d_q[1]), 32'h5A);
        chk("eb_beat2_last", 32'(pop_l_q[1]), 0);
        chk("eb_beat3_last", 32'(pop_l_q[2]), 0);
        chk("eb_beat4_last", 32'(pop_l_q[3]), 1);

        pop_d_q.delete();
        pop_l_q.delete();
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push_word(8'(8'hF0 + i));
        repeat (4) cycle();
        chk("fl_stalled_valid", 32'(s_vld), 1);
        m_ready = 1'b1;
        flush = 1'b1;
        cycle();
        chk("fl_rd_off", 32'(s_rd), 0);
        chk("fl_pop", 32'(s_dat), 32'hF1);
        flush = 1'b0;
        cycle();
        chk("fl_valid_drop", 32'(s_vld), 0);
        drain("fl_drain");
        chk("fl_count", pop_d_q.size(), 5);
        chk("fl_resume_data", 32'(pop_d_q[1]), 32'hF3);
        chk("fl_last_1", 32'(pop_l_q[1]), 0);
        chk("fl_last_2", 32'(pop_l_q[2]), 0);
        chk("fl_last_3", 32'(pop_l_q[3]), 0);
        chk("fl_last_4", 32'(pop_l_q[4]), 1);

        for (int i = 0; i < 1500; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) push_word(8'($urandom));
            flush = ($urandom_range(0, 39) == 0);
            cycle();
        end
        flush = 1'b0;
        drain("rnd_drain");
        chk("end_idle", 32'(vld[0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
